// File: rtl/uart_rx_ctrl_if.sv
// Bundles the UART RX controller's line, sampler and result signals.
// No latency of its own; it is wiring only.
// No backpressure: received bytes and error pulses are single-cycle strobes.
interface uart_rx_ctrl_if #(
    parameter int PRESCALE   = 32,
    parameter int DATA_WIDTH = 8
);
    localparam int PW = $clog2(PRESCALE) + 1;

    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PW-1:0]         prescale;
    logic                  sampled_bit;
    logic                  data_samp_en;
    logic [PW-1:0]         edge_cnt;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;

    // Line/sampler side: drives the serial line and voted bit, observes results.
    modport master (
        output RX_IN, PAR_EN, PAR_TYP, prescale, sampled_bit,
        input  data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err, strt_glitch
    );

    // Controller side.
    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, prescale, sampled_bit,
        output data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err, strt_glitch
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, edge/bit counting, deserialise, parity and stop check.
// Result strobe or error pulse lands (2+DATA_WIDTH+PAR_EN)*prescale cycles after the first START cycle.
// No backpressure: data_valid/par_err/stp_err/strt_glitch are one-cycle pulses that must be taken when seen.
module uart_rx_ctrl #(
    parameter int PRESCALE   = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_ctrl_if.slave bus
);
    localparam int PW = $clog2(PRESCALE) + 1;
    localparam int BW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_edge_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_flag;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  r_strt_glitch;

    logic                  w_bit_end;
    logic                  w_exp_par;

    // Last oversampling edge of the current bit; all bit decisions happen here.
    assign w_bit_end = (r_edge_cnt == (bus.prescale - PW'(1)));
    // Parity the frame should carry, using the per-frame latched parity type.
    assign w_exp_par = (^r_shift) ^ r_par_typ;

    // Controller FSM with counters, shift register and registered result pulses.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state       <= IDLE;
            r_edge_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_p_data      <= '0;
            r_par_en      <= 1'b0;
            r_par_typ     <= 1'b0;
            r_par_flag    <= 1'b0;
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_strt_glitch <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_strt_glitch <= 1'b0;

            // Edge counter parks at 0 in IDLE so START begins at edge 0.
            if (r_state == IDLE || w_bit_end) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + PW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (!bus.RX_IN) begin
                        r_state    <= START;
                        r_par_en   <= bus.PAR_EN;
                        r_par_typ  <= bus.PAR_TYP;
                        r_par_flag <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        if (!bus.sampled_bit) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            // Line went low but the vote says high: noise, not a frame.
                            r_state       <= IDLE;
                            r_strt_glitch <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        // Shift right so the first bit received ends up in bit 0.
                        r_shift   <= {bus.sampled_bit, r_shift[DATA_WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                        if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            r_state <= r_par_en ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        if (bus.sampled_bit != w_exp_par) begin
                            r_par_flag <= 1'b1;
                        end
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_state <= IDLE;
                        if (r_par_flag || !bus.sampled_bit) begin
                            r_par_err <= r_par_flag;
                            r_stp_err <= !bus.sampled_bit;
                        end else begin
                            r_data_valid <= 1'b1;
                            r_p_data     <= r_shift;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sampler runs whenever a frame is in progress.
    assign bus.data_samp_en = (r_state != IDLE);
    assign bus.edge_cnt     = r_edge_cnt;
    assign bus.P_DATA       = r_p_data;
    assign bus.data_valid   = r_data_valid;
    assign bus.par_err      = r_par_err;
    assign bus.stp_err      = r_stp_err;
    assign bus.strt_glitch  = r_strt_glitch;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed frames, scoreboarded result pulses.
// Expected pulse kind, data and exact cycle are queued when a frame starts.
// A negedge monitor pops and compares on every pulse the DUT raises.
module tb_uart_rx_ctrl;
    localparam int PW = 6;

    typedef struct {
        logic [3:0] kind;   // {data_valid, par_err, stp_err, strt_glitch}
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic [7:0] last_good = 8'h00;
    exp_t exp_q[$];
    int   valid_t[$];

    uart_rx_ctrl_if #(.PRESCALE(32), .DATA_WIDTH(8)) bus ();

    uart_rx_ctrl #(.PRESCALE(32), .DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [3:0] k;
        exp_t e;
        k = {bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch};
        if (rst && k != 4'b0000) begin
            if (bus.data_valid) valid_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'(k), 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", int'(k), int'(e.kind));
                check("p_data", int'(bus.P_DATA), int'(e.data));
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input logic b);
        bus.RX_IN       = b;
        bus.sampled_bit = b;
    endtask

    task automatic idle(input int n);
        drive(1'b1);
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame starting at the current negedge; queues the expected result.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pb, input logic stop_b, input int p,
                              input logic [3:0] kind);
        int   d0;
        exp_t e;
        bus.prescale = PW'(p);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        drive(1'b0);
        @(negedge clk);
        d0 = cyc;                       // DUT is in its first START cycle now
        bus.PAR_EN  = ~pe;              // must be ignored until the next frame
        bus.PAR_TYP = ~pt;
        e.kind = kind;
        e.data = (kind == 4'b1000) ? d : last_good;
        e.cyc  = d0 + (10 + int'(pe)) * p;
        exp_q.push_back(e);
        if (kind == 4'b1000) last_good = d;
        repeat (p) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            drive(d[k]);
            repeat (p) @(negedge clk);
        end
        if (pe) begin
            drive(pb);
            repeat (p) @(negedge clk);
        end
        drive(stop_b);
        repeat (p) @(negedge clk);
        bus.PAR_EN  = pe;
        bus.PAR_TYP = pt;
        drive(1'b1);                    // first IDLE cycle; caller may start the next frame here
    endtask

    initial begin
        int d0;
        bus.RX_IN       = 1'b1;
        bus.sampled_bit = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.PAR_TYP     = 1'b0;
        bus.prescale    = PW'(8);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_p_data", int'(bus.P_DATA), 0);
        check("rst_edge_cnt", int'(bus.edge_cnt), 0);
        check("rst_samp_en", int'(bus.data_samp_en), 0);
        check("rst_pulses", int'({bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch}), 0);
        rst = 1'b1;
        idle(4);

        // 1: p=8, no parity, 0xA5 -> valid at cycle 80
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, 4'b1000);
        idle(5);
        check("idle_samp_en", int'(bus.data_samp_en), 0);

        // 2: p=8, even parity: good, bad parity, then odd parity good
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8, 4'b1000);
        idle(5);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8, 4'b0100);
        idle(5);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8, 4'b1000);
        idle(5);

        // 3: p=16, 0x5A with stop bit 0 -> stp_err at cycle 160
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 16, 4'b0010);
        idle(5);

        // Parity and stop errors together: 0x01 even parity wants 1, send 0, stop 0
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8, 4'b0110);
        idle(5);

        // 4: start glitch, RX low 2 cycles, vote says 1 -> strt_glitch in cycle 8
        bus.prescale = PW'(8);
        bus.RX_IN       = 1'b0;
        bus.sampled_bit = 1'b1;
        @(negedge clk);
        d0 = cyc;
        begin
            exp_t e;
            e.kind = 4'b0001; e.data = last_good; e.cyc = d0 + 8;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (7) @(negedge clk);
        check("glitch_samp_en", int'(bus.data_samp_en), 0);
        check("glitch_edge_cnt", int'(bus.edge_cnt), 0);
        idle(5);

        // 5: p=16 back-to-back 0x01, 0xFE; one IDLE cycle separates frames
        valid_t.delete();
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 16, 4'b1000);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 16, 4'b1000);
        idle(5);
        check("b2b_valid_count", valid_t.size(), 2);
        check("b2b_valid_gap", (valid_t.size() >= 2) ? valid_t[1] - valid_t[0] : -1, 161);

        // 6: reset during data bit 4, then 0x81 must be received cleanly
        bus.prescale = PW'(8);
        drive(1'b0);
        @(negedge clk);
        repeat (8) @(negedge clk);              // start bit
        for (int k = 0; k < 4; k++) begin
            drive(1'b1);
            repeat (8) @(negedge clk);
        end
        drive(1'b1);
        repeat (3) @(negedge clk);              // inside data bit 4
        check("mid_samp_en", int'(bus.data_samp_en), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_samp_en", int'(bus.data_samp_en), 0);
        check("mid_rst_edge_cnt", int'(bus.edge_cnt), 0);
        check("mid_rst_p_data", int'(bus.P_DATA), 0);
        last_good = 8'h00;
        idle(20);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8, 4'b1000);
        idle(10);

        check("missing_pulses", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
